// File: rtl/video_stream_monitor.sv
// Passive monitor for the core video bus: measures raster timing and a per-frame
// pixel checksum, publishing the results at every VS rising edge.
module video_stream_monitor #(
  parameter int HW = 12,
  parameter int VW = 11
) (
  input  logic          clk_core_12288,
  input  logic          reset_n,
  input  logic [23:0]   video_rgb,
  input  logic          video_de,
  input  logic          video_skip,
  input  logic          video_hs,
  input  logic          video_vs,
  input  logic          err_clear,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic [31:0]   checksum,
  output logic [15:0]   frame_count,
  output logic          frame_done,
  output logic          results_valid,
  output logic          err_hmismatch
);

  typedef enum logic {WAIT_VS, MEASURE} state_t;

  state_t state_reg, state_next;

  // Stage 1: raw input register plus previous sync levels for edge detection.
  logic [23:0] rgb_q;
  logic        de_q, skip_q, hs_q, vs_q, hs_prev, vs_prev;

  // Stage 2: registered edges and pixel qualifier, kept aligned with the pixel data.
  logic [23:0] rgb_s;
  logic        pix_s, hs_edge, vs_edge;

  logic [HW-1:0] clk_cnt, line_pix, first_pix, ht_acc, ha_acc;
  logic [VW-1:0] vt_acc, va_acc;
  logic [31:0]   cs_acc;
  logic          first_valid, mm_acc;

  logic [HW-1:0] clk_cnt_next, ht_close, ha_close, fp_close, ha_pub, partial;
  logic [HW-1:0] line_base, line_inc;
  logic [VW-1:0] vt_close, va_close, va_pub;
  logic          fv_close, mm_close, mm_pub, publish;
  logic [31:0]   pix_add;

  always_ff @(posedge clk_core_12288 or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q   <= '0;
      de_q    <= 1'b0;
      skip_q  <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      rgb_s   <= '0;
      pix_s   <= 1'b0;
      hs_edge <= 1'b0;
      vs_edge <= 1'b0;
    end else begin
      rgb_q   <= video_rgb;
      de_q    <= video_de;
      skip_q  <= video_skip;
      hs_q    <= video_hs;
      vs_q    <= video_vs;
      hs_prev <= hs_q;
      vs_prev <= vs_q;
      rgb_s   <= rgb_q;
      pix_s   <= de_q & ~skip_q;
      hs_edge <= hs_q & ~hs_prev;
      vs_edge <= vs_q & ~vs_prev;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == WAIT_VS && vs_edge) state_next = MEASURE;

    // Line close on HS: always applied before any coincident frame close.
    ht_close = hs_edge ? clk_cnt : ht_acc;
    vt_close = vt_acc;
    if (hs_edge && vt_acc != '1) vt_close = vt_acc + 1'b1;
    va_close = va_acc;
    ha_close = ha_acc;
    fp_close = first_pix;
    fv_close = first_valid;
    mm_close = mm_acc;
    if (hs_edge && line_pix != '0) begin
      if (va_acc != '1) va_close = va_acc + 1'b1;
      ha_close = line_pix;
      if (first_valid) begin
        if (line_pix != first_pix) mm_close = 1'b1;
      end else begin
        fp_close = line_pix;
        fv_close = 1'b1;
      end
    end

    // Frame close: the partial line is empty when HS closed it this cycle.
    partial = hs_edge ? '0 : line_pix;
    va_pub  = va_close;
    ha_pub  = ha_close;
    mm_pub  = mm_close;
    if (vs_edge && partial != '0) begin
      if (va_close != '1) va_pub = va_close + 1'b1;
      ha_pub = partial;
      if (fv_close && partial != fp_close) mm_pub = 1'b1;
    end

    publish      = vs_edge && (state_reg == MEASURE);
    pix_add      = pix_s ? {8'h00, rgb_s} : 32'h0;
    line_base    = hs_edge ? '0 : line_pix;
    line_inc     = (pix_s && line_base != '1) ? line_base + 1'b1 : line_base;
    clk_cnt_next = hs_edge ? HW'(1) : ((clk_cnt == '1) ? clk_cnt : clk_cnt + 1'b1);
  end

  always_ff @(posedge clk_core_12288 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= WAIT_VS;
      clk_cnt       <= '0;
      line_pix      <= '0;
      first_pix     <= '0;
      first_valid   <= 1'b0;
      ht_acc        <= '0;
      ha_acc        <= '0;
      vt_acc        <= '0;
      va_acc        <= '0;
      cs_acc        <= '0;
      mm_acc        <= 1'b0;
      h_total       <= '0;
      h_active      <= '0;
      v_total       <= '0;
      v_active      <= '0;
      checksum      <= '0;
      frame_count   <= '0;
      frame_done    <= 1'b0;
      results_valid <= 1'b0;
      err_hmismatch <= 1'b0;
    end else begin
      state_reg <= state_next;
      clk_cnt   <= clk_cnt_next;

      // The pixel sampled on a VS edge cycle seeds the new frame.
      if (vs_edge || state_reg == WAIT_VS) begin
        ht_acc      <= '0;
        ha_acc      <= '0;
        vt_acc      <= '0;
        va_acc      <= '0;
        first_pix   <= '0;
        first_valid <= 1'b0;
        mm_acc      <= 1'b0;
        cs_acc      <= pix_add;
        line_pix    <= {{(HW-1){1'b0}}, pix_s};
      end else begin
        ht_acc      <= ht_close;
        ha_acc      <= ha_close;
        vt_acc      <= vt_close;
        va_acc      <= va_close;
        first_pix   <= fp_close;
        first_valid <= fv_close;
        mm_acc      <= mm_close;
        cs_acc      <= cs_acc + pix_add;
        line_pix    <= line_inc;
      end

      frame_done <= publish;
      if (publish) begin
        h_total       <= ht_close;
        h_active      <= ha_pub;
        v_total       <= vt_close;
        v_active      <= va_pub;
        checksum      <= cs_acc;
        frame_count   <= frame_count + 16'd1;
        results_valid <= 1'b1;
      end

      if (publish && mm_pub)
        err_hmismatch <= 1'b1;
      else if (err_clear)
        err_hmismatch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_stream_monitor.sv
// Directed bench for video_stream_monitor: a small raster model queues the expected
// results at every VS it drives and the monitor process checks each frame_done.
module tb_video_stream_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] rgb = '0;
  logic        de = 1'b0, skip = 1'b0, hs = 1'b0, vs = 1'b0, err_clear = 1'b0;
  logic [11:0] h_total, h_active;
  logic [10:0] v_total, v_active;
  logic [31:0] checksum;
  logic [15:0] frame_count;
  logic        frame_done, results_valid, err_hmismatch;

  video_stream_monitor dut (
    .clk_core_12288(clk),
    .reset_n       (reset_n),
    .video_rgb     (rgb),
    .video_de      (de),
    .video_skip    (skip),
    .video_hs      (hs),
    .video_vs      (vs),
    .err_clear     (err_clear),
    .h_total       (h_total),
    .h_active      (h_active),
    .v_total       (v_total),
    .v_active      (v_active),
    .checksum      (checksum),
    .frame_count   (frame_count),
    .frame_done    (frame_done),
    .results_valid (results_valid),
    .err_hmismatch (err_hmismatch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          ht, ha, vt, va;
    logic [31:0] cs;
    int          fc;
    bit          err;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0, n_pass = 0, n_fail = 0;

  // Raster model state for the frame currently being driven.
  int          last_hs = -1, line_pix_m = 0, first_m = -1;
  int          ht_m = 0, ha_m = 0, vt_m = 0, va_m = 0, fc_m = 0;
  logic [31:0] cs_m = '0;
  bit          mm_m = 1'b0, armed = 1'b0, err_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_frame();
    ht_m = 0; ha_m = 0; vt_m = 0; va_m = 0; cs_m = '0;
    first_m = -1; mm_m = 1'b0; line_pix_m = 0;
  endtask

  task automatic close_nonempty(input int n);
    if (va_m < 2047) va_m++;
    ha_m = n;
    if (first_m < 0) first_m = n;
    else if (n != first_m) mm_m = 1'b1;
  endtask

  // One 16-clock line: HS for 2 clk, VS for vs_len clk, DE from clock 4.
  task automatic drive_line(input bit hs_on, input int vs_len, input int de_n, input int skip_n);
    int d;
    for (int c = 0; c < 16; c++) begin
      hs   = hs_on && (c < 2);
      vs   = (c < vs_len);
      de   = (c >= 4) && (c < 4 + de_n);
      skip = (c >= 4) && (c < 4 + skip_n);
      rgb  = 24'h010203;
      if (c == 0) begin
        if (hs_on) begin
          d = (last_hs < 0) ? 0 : cyc - last_hs;
          ht_m = (d > 4095) ? 4095 : d;
          last_hs = cyc;
          if (vt_m < 2047) vt_m++;
          if (line_pix_m > 0) close_nonempty(line_pix_m);
          line_pix_m = 0;
        end
        if (vs_len > 0) begin
          if (line_pix_m > 0) close_nonempty(line_pix_m);
          if (armed) begin
            fc_m  = (fc_m + 1) & 16'hFFFF;
            err_m = err_m | mm_m;
            sb.push_back('{ht_m, ha_m, vt_m, va_m, cs_m, fc_m, err_m, cyc + 3});
          end
          clear_frame();
          armed = 1'b1;
        end
      end
      if (de && !skip) begin
        line_pix_m++;
        cs_m = cs_m + 32'h0001_0203;
      end
      @(negedge clk);
    end
  endtask

  // Six-line frame: VS+HS on line 0, active pixels on lines 1-4.
  task automatic drive_frame(input int skip_n, input int short_line);
    drive_line(1'b1, 3, 0, 0);
    for (int l = 1; l <= 4; l++)
      drive_line(1'b1, 0, (l == short_line) ? 9 : 10, skip_n);
    drive_line(1'b1, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_h_total"}, h_total, 0);
    check({tag, "_h_active"}, h_active, 0);
    check({tag, "_v_total"}, v_total, 0);
    check({tag, "_v_active"}, v_active, 0);
    check({tag, "_checksum"}, checksum, 0);
    check({tag, "_frame_count"}, frame_count, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_results_valid"}, results_valid, 0);
    check({tag, "_err"}, err_hmismatch, 0);
  endtask

  always @(negedge clk) begin
    if (reset_n && frame_done) begin
      exp_t e;
      check("publish_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("publish fc=%0d h_total=%0d h_active=%0d v_total=%0d v_active=%0d checksum=%08h err=%0b",
                 frame_count, h_total, h_active, v_total, v_active, checksum, err_hmismatch);
        check("done_cycle", cyc, e.due);
        check("h_total", h_total, e.ht);
        check("h_active", h_active, e.ha);
        check("v_total", v_total, e.vt);
        check("v_active", v_active, e.va);
        check("checksum", checksum, e.cs);
        check("frame_count", frame_count, e.fc);
        check("err_hmismatch", err_hmismatch, e.err);
        check("results_valid", results_valid, 1);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    drive_frame(0, -1);                 // first VS only arms
    check("first_vs_valid", results_valid, 0);
    check("first_vs_count", frame_count, 0);
    drive_frame(0, -1);
    drive_frame(0, -1);
    drive_frame(2, -1);                 // two skipped pixels per line
    drive_frame(2, -1);
    drive_frame(0, 3);                  // line 3 one pixel short
    drive_frame(0, -1);
    drive_frame(0, -1);                 // clean frame; error stays sticky

    check("err_sticky", err_hmismatch, 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    err_m = 1'b0;
    check("err_cleared", err_hmismatch, 0);
    repeat (4999) @(negedge clk);       // long HS-less gap saturates the clock counter
    drive_line(1'b1, 0, 0, 0);
    drive_line(1'b0, 3, 0, 0);          // VS alone publishes h_total=4095

    drive_line(1'b1, 0, 10, 0);         // mid-frame, then reset
    drive_line(1'b1, 0, 10, 0);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    armed = 1'b0; fc_m = 0; err_m = 1'b0; last_hs = -1;
    clear_frame();
    check("sb_empty_at_reset", sb.size(), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    drive_frame(0, -1);
    check("post_reset_valid", results_valid, 0);
    check("post_reset_count", frame_count, 0);
    drive_frame(0, -1);
    drive_line(1'b1, 3, 0, 0);
    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
